aes_key_expand_seq: RTL and testbench

Iterative AES-128 key expansion engine that sits directly upstream of the decryption datapath. It accepts a 128-bit cipher key via a valid/ready handshake and computes round keys 1..10 at one per cycle, storing all eleven keys (0..10). It then serves any round key through a registered read port. The decrypt stages consume the keys in reverse order (10 down to 0), so all keys must be available before decryption starts.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_key_step.sv | 27 ++
 rtl/aes_key_expand_seq.sv | 111 +++++++++++
 tb/tb_aes_key_expand_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: sizes, state encoding, S-box and round constants.
package aes_pkg;

    localparam int NR = 10;
    localparam int KW = 128;

    typedef logic [KW-1:0] rk_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index 0 is unused; round r uses RCON[r].
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule round: derives round key r from round key r-1 and RCON[r].
module aes_key_step
    import aes_pkg::*;
(
    input  rk_t        prev_key_i,
    input  logic [7:0] rcon_i,
    output rk_t        next_key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0 = prev_key_i[127:96];
        w1 = prev_key_i[95:64];
        w2 = prev_key_i[63:32];
        w3 = prev_key_i[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_i, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_key_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: stores round keys 0..10 and serves them on a registered read port.
// Optional macro AES_KEY_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic          zeroize,
`endif
    input  logic          key_valid,
    input  logic [KW-1:0] key_in,
    output logic          key_ready,
    output logic          busy,
    output logic          keys_valid,
    output logic          done,
    input  logic [3:0]    rk_addr,
    output logic [KW-1:0] rk_data
);

    localparam logic [3:0] LAST = 4'(NR);

    state_e     state_q, state_d;
    logic [3:0] cnt_q;
    rk_t        rk_q [0:NR];
    rk_t        rk_data_q;
    logic       done_q;
    rk_t        prev_key, next_key;
    logic [7:0] rcon;
    logic       wipe;

`ifdef AES_KEY_ZEROIZE_EN
    assign wipe = zeroize;
`else
    assign wipe = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (wipe) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (key_valid) state_d = EXPAND;
                EXPAND:  if (cnt_q == LAST) state_d = DONE;
                DONE:    if (key_valid) state_d = EXPAND;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        key_ready  = (state_q != EXPAND);
        busy       = (state_q == EXPAND);
        keys_valid = (state_q == DONE);
        done       = done_q;
        rk_data    = rk_data_q;
    end

    // Only rounds 1..10 feed the step; other counts present a benign zero input.
    always_comb begin
        prev_key = '0;
        rcon     = 8'h00;
        if (cnt_q != 4'd0 && cnt_q <= LAST) begin
            prev_key = rk_q[cnt_q - 4'd1];
            rcon     = RCON[cnt_q];
        end
    end

    aes_key_step u_step (
        .prev_key_i (prev_key),
        .rcon_i     (rcon),
        .next_key_o (next_key)
    );

    always_ff @(posedge clk) begin
        if (rst || wipe) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
            rk_data_q <= '0;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            rk_data_q <= (rk_addr <= LAST) ? rk_q[rk_addr] : '0;
            case (state_q)
                IDLE, DONE: begin
                    if (key_valid) begin
                        rk_q[0] <= key_in;
                        cnt_q   <= 4'd1;
                    end
                end
                EXPAND: begin
                    rk_q[cnt_q] <= next_key;
                    if (cnt_q == LAST) begin
                        cnt_q  <= 4'd0;
                        done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: cnt_q <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 key-schedule vectors.
module tb_aes_key_expand_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready, busy, keys_valid, done;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K3     = 128'hffeeddccbbaa99887766554433221100;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk        (clk),
        .rst        (rst),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .busy       (busy),
        .keys_valid (keys_valid),
        .done       (done),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_key(input logic [3:0] addr, input string tag, input logic [127:0] exp);
        rk_addr = addr;
        tick();
        check(tag, rk_data, exp);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_addr = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check("reset_key_ready",  128'(key_ready),  128'd1);
        check("reset_busy",       128'(busy),       128'd0);
        check("reset_keys_valid", 128'(keys_valid), 128'd0);
        check("reset_done",       128'(done),       128'd0);
        check("reset_rk_data",    rk_data,          128'd0);

        // Key 1: handshake at edge T, done visible only after edge T+10
        key_valid = 1'b1; key_in = K1;
        tick();
        key_valid = 1'b0;
        check("k1_busy",      128'(busy),      128'd1);
        check("k1_key_ready", 128'(key_ready), 128'd0);
        done_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            done_cnt += int'(done) + int'(keys_valid);
        end
        check("k1_no_early_done", 128'(done_cnt), 128'd0);
        tick();
        check("k1_done_T10",       128'(done),       128'd1);
        check("k1_keys_valid_T10", 128'(keys_valid), 128'd1);
        check("k1_busy_T10",       128'(busy),       128'd0);
        tick();
        check("k1_done_one_cycle", 128'(done),       128'd0);
        check("k1_keys_valid_hold", 128'(keys_valid), 128'd1);
        read_key(4'd1,  "k1_rk1",  K1_R1);
        read_key(4'd10, "k1_rk10", K1_R10);
        read_key(4'd0,  "k1_rk0",  K1);

        // Key 2 loaded from DONE; a competing key during EXPAND must be ignored
        key_valid = 1'b1; key_in = K2;
        tick();
        check("k2_keys_valid_drop", 128'(keys_valid), 128'd0);
        key_in = K3;
        done_cnt = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            done_cnt += int'(done);
        end
        key_valid = 1'b0;
        tick();
        check("k2_done_T10", 128'(done), 128'd1);
        done_cnt += int'(done);
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += int'(done);
        end
        check("k2_single_done",  128'(done_cnt),   128'd1);
        check("k2_keys_valid",   128'(keys_valid), 128'd1);
        read_key(4'd10, "k2_rk10",   K2_R10);
        read_key(4'd0,  "k2_rk0",    K2);
        read_key(4'd15, "k2_addr15", 128'd0);

        // Reset in the middle of an expansion
        key_valid = 1'b1; key_in = K1;
        tick();
        key_valid = 1'b0;
        rk_addr = 4'd0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_key_ready",  128'(key_ready),  128'd1);
        check("rst_busy",       128'(busy),       128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_done",       128'(done),       128'd0);
        check("rst_rk_data",    rk_data,          128'd0);
        read_key(4'd3,  "rst_rk3",  128'd0);
        read_key(4'd0,  "rst_rk0",  128'd0);
        read_key(4'd10, "rst_rk10", 128'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            done_cnt += int'(done);
        end
        check("rst_no_done", 128'(done_cnt), 128'd0);

`ifdef AES_KEY_ZEROIZE_EN
        key_valid = 1'b1; key_in = K1;
        tick();
        key_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("zz_keys_valid_pre", 128'(keys_valid), 128'd1);
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        check("zz_keys_valid", 128'(keys_valid), 128'd0);
        check("zz_rk_data",    rk_data,          128'd0);
        read_key(4'd10, "zz_rk10", 128'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
